// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding and instruction size.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/branch handshake bundle between the PC sequencer (master) and the pipeline (slave).
interface pc_sequencer_if;

    logic        stall;
    logic        fetchReady;
    logic        brValid;
    logic        brTaken;
    logic [31:0] brPc;
    logic [31:0] brInstruction;
    logic [31:0] pc;
    logic        pcValid;
    logic        flush;

    modport master (
        input  stall, fetchReady, brValid, brTaken, brPc, brInstruction,
        output pc, pcValid, flush
    );

    modport slave (
        output stall, fetchReady, brValid, brTaken, brPc, brInstruction,
        input  pc, pcValid, flush
    );

endinterface

// File: rtl/pc_sequencer_branch_targ_gen.sv
// Branch target generator: brPc plus the sign-extended B-type immediate, modulo 2^32.
module BranchTargGen (
    input  logic [31:0] br_pc,
    input  logic [31:0] inst,
    output logic [31:0] target
);

    logic [31:0] imm_s;
    logic        unused_inst_s;

    assign imm_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign target = br_pc + imm_s;

    // Opcode, register and funct fields carry no immediate bits.
    assign unused_inst_s = ^{inst[24:12], inst[6:0]};

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: BOOT/RUN/PEND fetch FSM with branch redirect and one-cycle flush.
// Optional macro PC_SEQUENCER_STATS_EN adds a saturating redirectCount output.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
`ifdef PC_SEQUENCER_STATS_EN
    ,
    output logic [15:0]    redirectCount
`endif
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        flush_q, flush_d;
    logic [31:0] target_s;
    logic        pc_valid_s;
    logic        transfer_s;
    logic        br_take_s;
    logic        load_s;

    BranchTargGen u_targ_gen (
        .br_pc  (bus.brPc),
        .inst   (bus.brInstruction),
        .target (target_s)
    );

    assign pc_valid_s  = (state_q != BOOT) && !bus.stall;
    assign transfer_s  = pc_valid_s && bus.fetchReady;
    // Resolutions seen during the flush cycle belong to the killed wrong path.
    assign br_take_s   = bus.brValid && bus.brTaken && !flush_q;

    assign bus.pc      = pc_q;
    assign bus.pcValid = pc_valid_s;
    assign bus.flush   = flush_q;

    // Next-state, next-pc and redirect bookkeeping.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        load_s        = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (br_take_s) begin
                    if (transfer_s) begin
                        pc_d   = target_s;
                        load_s = 1'b1;
                    end else begin
                        pend_target_d = target_s;
                        state_d       = PEND;
                    end
                end else if (transfer_s) begin
                    pc_d = pc_q + INSTR_BYTES;
                end else begin
                    pc_d = pc_q;
                end
            end
            PEND: begin
                if (transfer_s) begin
                    pc_d    = pend_target_q;
                    load_s  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = PEND;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        flush_d = load_s;
    end

    // State, pc, pending target and flush registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            pend_target_q <= 32'h0000_0000;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            flush_q       <= flush_d;
        end
    end

`ifdef PC_SEQUENCER_STATS_EN
    logic [15:0] redirect_count_q, redirect_count_d;

    // Saturating count of target loads into pc.
    always_comb begin
        if (load_s && (redirect_count_q != 16'hFFFF)) begin
            redirect_count_d = redirect_count_q + 16'd1;
        end else begin
            redirect_count_d = redirect_count_q;
        end
    end

    // Statistics register.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_count_q <= 16'h0000;
        end else begin
            redirect_count_q <= redirect_count_d;
        end
    end

    assign redirectCount = redirect_count_q;
`endif

endmodule
